// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, FSM encoding
// and the access legality rule.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_CORE = 2'd1,
    GNT_DBG  = 2'd2
  } arb_state_t;

  // Unsigned widths are load-only; halfword/word need natural alignment.
  function automatic logic access_legal(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational legality check applied to the request currently holding the
// memory port.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic       we,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output logic       legal
);

  assign legal = access_legal(we, funct3, addr_lo);

endmodule

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter and sequencer for the single-port data memory.
// Optional starvation guard for the debug port: define DMEM_ARB_FAIRNESS_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [2:0]            core_funct3,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [2:0]            dbg_funct3,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  core_ack,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_err,
  output logic                  core_stall,
  output logic                  dbg_ack,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  arb_state_t state, state_nxt;

  logic                  sel_we;
  logic [2:0]            sel_funct3;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  legal;
  logic                  dbg_first;
  logic [DATA_WIDTH-1:0] load_data;

`ifdef DMEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_cnt <= '0;
    else if (state == GNT_DBG || !dbg_req) starve_cnt <= '0;
    else if (state == GNT_CORE && starve_cnt < CNT_W'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + CNT_W'(1);
  end

  assign dbg_first = (starve_cnt >= CNT_W'(STARVE_LIMIT));
`else
  // Limit is inert without the counter; a negative limit is never configured.
  assign dbg_first = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The port holding the grant is left out, so back-to-back grants alternate.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      GNT_CORE: if (dbg_req) state_nxt = GNT_DBG;
      GNT_DBG:  if (core_req) state_nxt = GNT_CORE;
      default: begin
        if (dbg_req && dbg_first) state_nxt = GNT_DBG;
        else if (core_req)        state_nxt = GNT_CORE;
        else if (dbg_req)         state_nxt = GNT_DBG;
      end
    endcase
  end

  always_comb begin
    sel_we     = 1'b0;
    sel_funct3 = '0;
    sel_addr   = '0;
    sel_wdata  = '0;
    case (state)
      GNT_CORE: begin
        sel_we     = core_we;
        sel_funct3 = core_funct3;
        sel_addr   = core_addr;
        sel_wdata  = core_wdata;
      end
      GNT_DBG: begin
        sel_we     = dbg_we;
        sel_funct3 = dbg_funct3;
        sel_addr   = dbg_addr;
        sel_wdata  = dbg_wdata;
      end
      default: ;
    endcase
  end

  dmem_align_chk u_align_chk (
    .we      (sel_we),
    .funct3  (sel_funct3),
    .addr_lo (sel_addr[1:0]),
    .legal   (legal)
  );

  assign core_ack    = (state == GNT_CORE);
  assign dbg_ack     = (state == GNT_DBG);
  assign core_stall  = core_req & ~core_ack;

  assign mem_wr_en   = (core_ack | dbg_ack) & sel_we & legal;
  assign mem_funct3  = sel_funct3;
  assign mem_addr    = sel_addr;
  assign mem_wr_data = sel_wdata;

  assign load_data   = (legal & ~sel_we) ? mem_rd_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_rvalid <= 1'b0;
      core_err    <= 1'b0;
      core_rdata  <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_err     <= 1'b0;
      dbg_rdata   <= '0;
    end else begin
      core_rvalid <= core_ack;
      core_err    <= core_ack & ~legal;
      dbg_rvalid  <= dbg_ack;
      dbg_err     <= dbg_ack & ~legal;
      if (core_ack) core_rdata <= load_data;
      if (dbg_ack)  dbg_rdata  <= load_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner cases and
// a randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, dbg_req, dbg_we;
  logic [2:0]    core_funct3, dbg_funct3;
  logic [AW-1:0] core_addr, dbg_addr;
  logic [DW-1:0] core_wdata, dbg_wdata;
  logic          core_ack, core_rvalid, core_err, core_stall;
  logic          dbg_ack, dbg_rvalid, dbg_err;
  logic [DW-1:0] core_rdata, dbg_rdata;
  logic          mem_wr_en;
  logic [2:0]    mem_funct3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  logic [31:0] mem     [0:15];
  logic [31:0] ref_mem [0:15];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr[5:2]];

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_funct3(dbg_funct3),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .core_ack(core_ack), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .core_err(core_err), .core_stall(core_stall),
    .dbg_ack(dbg_ack), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  typedef struct {
    bit          p;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[16];

  bit          r_req[2];
  bit          r_we[2];
  logic [2:0]  r_f3[2];
  logic [31:0] r_a[2];
  logic [31:0] r_wd[2];
  bit          e_rv[2];
  bit          e_err[2];
  logic [31:0] e_rd[2];
  logic [2:0]  legal_codes[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  function automatic bit ref_legal(bit we, logic [2:0] f3, logic [1:0] lo);
    bit known;
    int size;
    known = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    return known && ((int'(lo) % size) == 0);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [2:0] f3, logic [1:0] lo,
                                        logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (f3[1:0])
      2'd0:    r[8*lo +: 8] = wd[7:0];
      2'd1:    r[16*lo[1] +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Grant for the next cycle from the pending requests, skipping the current holder.
  function automatic int pick(bit creq, bit dreq, int last);
    if (creq && last != 1) return 1;
    if (dreq && last != 2) return 2;
    return 0;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Memory write lands mid-cycle, after the DUT has settled its grant-cycle outputs.
  task automatic to_neg();
    @(negedge clk);
    if (mem_wr_en === 1'b1)
      mem[mem_addr[5:2]] = merge(mem[mem_addr[5:2]], mem_funct3, mem_addr[1:0], mem_wr_data);
  endtask

  task automatic set_port(input bit p, input bit req, input bit we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin
      core_req = req; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd;
    end else begin
      dbg_req = req; dbg_we = we; dbg_funct3 = f3; dbg_addr = a; dbg_wdata = wd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      to_drive();
      to_neg();
    end
  endtask

  task automatic single(input string tag, input bit p, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit exp_err,
                        input logic [31:0] exp_rd);
    to_drive();
    set_port(p, 1'b1, we, f3, a, wd);
    to_neg();
    chk1({tag, ".ack_early"}, p ? dbg_ack : core_ack, 1'b0);
    to_drive();
    to_neg();
    chk1({tag, ".ack"}, p ? dbg_ack : core_ack, 1'b1);
    chk1({tag, ".wr_en"}, mem_wr_en, we & ~exp_err);
    chk32({tag, ".mem_addr"}, mem_addr, a);
    to_drive();
    set_port(p, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    to_neg();
    chk1({tag, ".rvalid"}, p ? dbg_rvalid : core_rvalid, 1'b1);
    chk1({tag, ".err"}, p ? dbg_err : core_err, exp_err);
    chk32({tag, ".rdata"}, p ? dbg_rdata : core_rdata, exp_rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g_prev, p, run, max_run, dbg_cnt, viol;
    bit pc_ack, pd_ack, leg;

    for (int i = 0; i < 16; i++) mem[i] = 32'hA0A0_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

    // Reset values
    reset = 1'b1;
    to_neg();
    chk1("rst.core_ack", core_ack, 1'b0);
    chk1("rst.dbg_ack", dbg_ack, 1'b0);
    chk1("rst.core_rvalid", core_rvalid, 1'b0);
    chk1("rst.dbg_rvalid", dbg_rvalid, 1'b0);
    chk1("rst.core_err", core_err, 1'b0);
    chk1("rst.dbg_err", dbg_err, 1'b0);
    chk32("rst.core_rdata", core_rdata, 32'd0);
    chk32("rst.dbg_rdata", dbg_rdata, 32'd0);
    chk1("rst.mem_wr_en", mem_wr_en, 1'b0);
    chk32("rst.mem_addr", mem_addr, 32'd0);
    chk32("rst.mem_funct3", 32'(mem_funct3), 32'd0);
    chk32("rst.mem_wr_data", mem_wr_data, 32'd0);
    to_drive();
    reset = 1'b0;
    to_neg();

    // Vector table, applied in order; later entries rely on earlier stores.
    vt[0]  = '{1'b0, 1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 1'b1, 3'b001, 32'h03, 32'hFFFF,     1'b1, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 3'b011, 32'h08, 32'h0,        1'b1, 32'h0};
    vt[3]  = '{1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'h12345678};
    vt[5]  = '{1'b0, 1'b0, 3'b001, 32'h02, 32'h0,        1'b0, 32'hA0A00000};
    vt[6]  = '{1'b0, 1'b0, 3'b010, 32'h06, 32'h0,        1'b1, 32'h0};
    vt[7]  = '{1'b0, 1'b0, 3'b100, 32'h07, 32'h0,        1'b0, 32'hA0A00001};
    vt[8]  = '{1'b1, 1'b1, 3'b000, 32'h21, 32'hEE,       1'b0, 32'h0};
    vt[9]  = '{1'b1, 1'b1, 3'b001, 32'h22, 32'hBEEF,     1'b0, 32'h0};
    vt[10] = '{1'b0, 1'b0, 3'b010, 32'h20, 32'h0,        1'b0, 32'hBEEFEE78};
    vt[11] = '{1'b0, 1'b1, 3'b100, 32'h00, 32'hFFFFFFFF, 1'b1, 32'h0};
    vt[12] = '{1'b1, 1'b0, 3'b101, 32'h01, 32'h0,        1'b1, 32'h0};
    vt[13] = '{1'b0, 1'b0, 3'b010, 32'h00, 32'h0,        1'b0, 32'hA0A00000};
    vt[14] = '{1'b1, 1'b1, 3'b101, 32'h04, 32'h11111111, 1'b1, 32'h0};
    vt[15] = '{1'b1, 1'b0, 3'b000, 32'h0B, 32'h0,        1'b0, 32'hA0A00002};
    for (int i = 0; i < 16; i++)
      single($sformatf("vec%0d", i), vt[i].p, vt[i].we, vt[i].f3, vt[i].a, vt[i].wd,
             vt[i].err, vt[i].rd);

    // Simultaneous requests: core first reads old data, dbg store follows.
    to_drive();
    set_port(1'b0, 1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    set_port(1'b1, 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
    to_neg();
    chk1("sim.stall_wait", core_stall, 1'b1);
    to_drive();
    to_neg();
    chk1("sim.core_ack", core_ack, 1'b1);
    chk1("sim.dbg_ack_wait", dbg_ack, 1'b0);
    chk1("sim.stall_gnt", core_stall, 1'b0);
    to_drive();
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    to_neg();
    chk1("sim.dbg_ack", dbg_ack, 1'b1);
    chk1("sim.dbg_wr_en", mem_wr_en, 1'b1);
    chk1("sim.core_rvalid", core_rvalid, 1'b1);
    chk32("sim.core_rdata_old", core_rdata, 32'hA0A0000C);
    to_drive();
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    to_neg();
    chk1("sim.dbg_rvalid", dbg_rvalid, 1'b1);
    chk1("sim.dbg_err", dbg_err, 1'b0);
    chk32("sim.dbg_rdata", dbg_rdata, 32'h0);
    single("sim.reread", 1'b0, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'hCAFEF00D);

    // Both ports hold requests: dbg must not wait behind more than two core grants.
    to_drive();
    set_port(1'b0, 1'b1, 1'b0, 3'b010, 32'h00, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
    to_neg();
    run = 0; max_run = 0; dbg_cnt = 0; viol = 0; pc_ack = 1'b0; pd_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      to_drive();
      to_neg();
      if (core_ack) begin
        run++;
        if (run > max_run) max_run = run;
        if (pc_ack) viol++;
      end
      if (dbg_ack) begin
        run = 0;
        dbg_cnt++;
        if (pd_ack) viol++;
      end
      pc_ack = core_ack;
      pd_ack = dbg_ack;
    end
    chk1("fair.max_core_run", max_run <= 2, 1'b1);
    chk1("fair.dbg_grants", dbg_cnt >= 6, 1'b1);
    chk32("fair.back_to_back", 32'(viol), 32'd0);
    to_drive();
    set_port(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    to_neg();
    idle(2);

    // Reset during a dbg store grant: write is lost and no response follows.
    to_drive();
    set_port(1'b1, 1'b1, 1'b1, 3'b010, 32'h3C, 32'h55AA55AA);
    to_neg();
    to_drive();
    chk1("rst_mid.ack_before", dbg_ack, 1'b1);
    reset = 1'b1;
    to_neg();
    chk1("rst_mid.dbg_ack", dbg_ack, 1'b0);
    chk1("rst_mid.wr_en", mem_wr_en, 1'b0);
    chk32("rst_mid.mem_addr", mem_addr, 32'h0);
    to_drive();
    set_port(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    to_neg();
    chk1("rst_mid.rvalid_in_rst", dbg_rvalid, 1'b0);
    to_drive();
    reset = 1'b0;
    to_neg();
    chk1("rst_mid.rvalid_after", dbg_rvalid, 1'b0);
    to_drive();
    to_neg();
    chk1("rst_mid.rvalid_late", dbg_rvalid, 1'b0);
    single("rst_mid.reread", 1'b0, 1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'hA0A0000F);
    idle(2);

    // Randomized traffic against the transaction-level model.
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int q = 0; q < 2; q++) begin
      r_req[q] = 1'b0; r_we[q] = 1'b0; r_f3[q] = 3'd0; r_a[q] = 32'd0; r_wd[q] = 32'd0;
      e_rv[q] = 1'b0; e_err[q] = 1'b0; e_rd[q] = 32'd0;
    end
    g_prev = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      to_drive();
      g = pick(r_req[0], r_req[1], g_prev);
      for (int q = 0; q < 2; q++) begin
        if (!r_req[q] || g_prev == q + 1) begin
          r_req[q] = ($urandom_range(0, 9) < 6);
          r_we[q]  = $urandom_range(0, 1) == 1;
          r_f3[q]  = ($urandom_range(0, 3) != 0) ? legal_codes[$urandom_range(0, 4)]
                                                 : 3'($urandom_range(0, 7));
          r_a[q]   = $urandom_range(0, 63);
          r_wd[q]  = $urandom;
        end
        set_port(q[0], r_req[q], r_we[q], r_f3[q], r_a[q], r_wd[q]);
      end
      to_neg();
      chk1("rnd.core_ack", core_ack, g == 1);
      chk1("rnd.dbg_ack", dbg_ack, g == 2);
      chk1("rnd.core_stall", core_stall, r_req[0] && g != 1);
      chk1("rnd.core_rvalid", core_rvalid, e_rv[0]);
      chk1("rnd.dbg_rvalid", dbg_rvalid, e_rv[1]);
      if (e_rv[0]) begin
        chk1("rnd.core_err", core_err, e_err[0]);
        chk32("rnd.core_rdata", core_rdata, e_rd[0]);
      end
      if (e_rv[1]) begin
        chk1("rnd.dbg_err", dbg_err, e_err[1]);
        chk32("rnd.dbg_rdata", dbg_rdata, e_rd[1]);
      end
      e_rv[0] = (g == 1);
      e_rv[1] = (g == 2);
      if (g != 0) begin
        p = g - 1;
        leg = ref_legal(r_we[p], r_f3[p], r_a[p][1:0]);
        chk1("rnd.wr_en", mem_wr_en, r_we[p] && leg);
        chk32("rnd.mem_addr", mem_addr, r_a[p]);
        chk32("rnd.mem_funct3", 32'(mem_funct3), 32'(r_f3[p]));
        chk32("rnd.mem_wr_data", mem_wr_data, r_wd[p]);
        e_err[p] = !leg;
        e_rd[p]  = (leg && !r_we[p]) ? ref_mem[r_a[p][5:2]] : 32'd0;
        if (leg && r_we[p])
          ref_mem[r_a[p][5:2]] = merge(ref_mem[r_a[p][5:2]], r_f3[p], r_a[p][1:0], r_wd[p]);
      end else begin
        chk1("rnd.idle_wr_en", mem_wr_en, 1'b0);
        chk32("rnd.idle_addr", mem_addr, 32'd0);
      end
      g_prev = g;
    end
    for (int i = 0; i < 16; i++) chk32($sformatf("rnd.mem%0d", i), mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port data memory. It shares the memory between the pipeline's MEM stage (core port) and a debug/loader port (dbg port). It registers each grant and returns registered read data with a response pulse. It also rejects misaligned or illegal-funct3 accesses before they reach the memory, so the memory never sees an unsupported access.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width.
- `DATA_WIDTH`, default 32: data width.
- `STARVE_LIMIT`, default 4: consecutive core grants allowed while dbg waits (fairness build only).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `core_req`, `dbg_req`  in  1  access request; held stable until that port's `*_ack`.
- `core_we`, `dbg_we`  in  1  1 = store, 0 = load.
- `core_funct3`, `dbg_funct3`  in  3  RV32I width/sign code.
- `core_addr`, `dbg_addr`  in  ADDR_WIDTH  byte address.
- `core_wdata`, `dbg_wdata`  in  DATA_WIDTH  store data.
- `core_ack`, `dbg_ack`  out  1  high during the port's grant cycle.
- `core_rvalid`, `dbg_rvalid`  out  1  one-cycle pulse the cycle after the grant.
- `core_rdata`, `dbg_rdata`  out  DATA_WIDTH  registered load data.
- `core_err`, `dbg_err`  out  1  with `*_rvalid`; access was rejected.
- `core_stall`  out  1  equals `core_req & ~core_ack`; feeds the hazard unit.
- `mem_wr_en`  out  1  memory port write enable.
- `mem_funct3`  out  3  memory port width/sign code.
- `mem_addr`  out  ADDR_WIDTH  memory port address.
- `mem_wr_data`  out  DATA_WIDTH  memory port store data.
- `mem_rd_data`  in  DATA_WIDTH  combinational read data from the memory.

## Operation
- FSM states: `IDLE`, `GNT_CORE`, `GNT_DBG`.
- Next-state selection runs from every state, using pending requests:
  - Core has fixed priority.
  - The port currently in its grant state is excluded from selection.
  - No pending request → `IDLE`.
- Back-to-back grants alternate naturally, so each port gets at most one access per two cycles.
- In `GNT_x`:
  - `mem_addr`, `mem_funct3` and `mem_wr_data` are driven from port x.
  - `mem_wr_en` = `x_we & legal`.
  - `x_ack` = 1.
- Outside grant states: all `mem_*` outputs are 0 and `mem_wr_en` is 0.
- Legality rules:
  - Loads: funct3 ∈ {000, 001, 010, 100, 101}.
  - Stores: funct3 ∈ {000, 001, 010}.
  - Halfword (001/101) requires `addr[0]` = 0.
  - Word (010) requires `addr[1:0]` = 0.
- Illegal access: no write, `x_rdata` = 0, `x_err` = 1 with `x_rvalid`.
- Legal load: `mem_rd_data` is captured at the end of the grant cycle.
- Legal store: `x_rvalid` pulses and `x_rdata` is 0.
- Port x must drop its request, or present a new one, the cycle after `x_ack`. A request still high is treated as a new access.

## Timing
- Reset values: state `IDLE`; all `*_ack`, `*_rvalid`, `*_err` = 0; `*_rdata` = 0; all `mem_*` = 0; starvation counter = 0.
- Latency: request seen in cycle N while `IDLE` → grant in N+1 → store commits at the end of N+1 → `rvalid` in N+2.
- Simultaneous requests from `IDLE`: core first, dbg next.
- Reset asserted mid-grant: any write not yet clocked is lost, and no `rvalid` follows.
- `*_rvalid` never pulses without a preceding `*_ack`.

## Configuration
- Macro `DMEM_ARB_FAIRNESS_EN`.
- Defined:
  - Saturating counter increments on each core grant while `dbg_req` is high; it clears on a dbg grant or when `dbg_req` is low.
  - When the counter reaches `STARVE_LIMIT`, the next selection goes to dbg even if core requests.
- Undefined: pure fixed priority, no counter. Dbg may starve only if core requests every cycle, which the alternation rule prevents.

## Structure
- Shared package `dmem_pkg`:
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum encoding.
  - Legality function `access_legal(we, funct3, addr_lo)`.
- Sub-module `dmem_align_chk`: combinational legality check, instantiated once on the muxed request.

## Test plan
- Core lw at 0x10 while mem holds 0xDEADBEEF → `core_ack` in N+1; `core_rvalid` and `core_rdata` = 0xDEADBEEF in N+2.
- Core and dbg request together: dbg sw 0x12345678 @0x20, core lw @0x20 → core granted first and reads old data; dbg granted next cycle; a later core lw returns 0x12345678.
- Core sh at 0x03 → `mem_wr_en` stays 0; `core_err` = 1 and `core_rdata` = 0 in N+2; memory unchanged.
- Dbg load with funct3 = 011 → `dbg_err` pulse; no memory write.
- Fairness build, `STARVE_LIMIT` = 2, core requests held and re-presented, dbg requesting → dbg granted after at most 2 core grants.
- Reset asserted during `GNT_DBG` of a store → state returns to `IDLE`; no `dbg_rvalid`; outputs at reset values.
